// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: drives the 4:1 mux selects through a..d, waits SETTLE
// cycles per channel, samples mux_out and publishes a 4-bit word.
//
// Ports:
//   clk      system clock, rising edge
//   reset    synchronous active-high reset
//   start    request one scan (sampled in IDLE only)
//   abort    cancel scan in progress (sampled in SCAN only)
//   mux_out  output of the external 4:1 mux
//   s1, s2   registered mux select, {s1,s2} = channel index
//   word     last completed scan, word[i] = channel i
//   valid    one-cycle pulse when word updates
//   busy     high while a scan is in progress
module mux_scan_ctrl #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       mux_out,
    output logic       s1,
    output logic       s2,
    output logic [3:0] word,
    output logic       valid,
    output logic       busy
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_chan;
    logic [3:0] r_cnt;
    logic [2:0] r_shadow;
    logic [3:0] r_word;
    logic       r_valid;
    logic       w_sample;
    logic       w_last;

    // Sample when the current channel has been stable for SETTLE cycles.
    assign w_sample = (r_state == SCAN) && (r_cnt == 4'(SETTLE - 1));
    assign w_last   = w_sample && (r_chan == 2'd3);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (start) w_next = SCAN;
            SCAN: if (abort || w_last) w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_chan   <= 2'd0;
            r_cnt    <= 4'd0;
            r_shadow <= 3'd0;
            r_word   <= 4'd0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    r_chan <= 2'd0;
                    r_cnt  <= 4'd0;
                end
                SCAN: begin
                    if (abort) begin
                        r_chan   <= 2'd0;
                        r_cnt    <= 4'd0;
                        r_shadow <= 3'd0;
                    end else if (w_sample) begin
                        r_cnt <= 4'd0;
                        if (w_last) begin
                            // Last channel goes straight into word, so
                            // word never shows a partial scan.
                            r_word   <= {mux_out, r_shadow};
                            r_valid  <= 1'b1;
                            r_chan   <= 2'd0;
                            r_shadow <= 3'd0;
                        end else begin
                            r_shadow[r_chan] <= mux_out;
                            r_chan           <= r_chan + 2'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        s1    = r_chan[1];
        s2    = r_chan[0];
        word  = r_word;
        valid = r_valid;
        busy  = (r_state == SCAN);
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: directed table, hand sequences and random stimulus
// for mux_scan_ctrl at SETTLE=2 (instance 0) and SETTLE=1 (instance 1).
module tb_mux_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst [2];
    logic       st  [2];
    logic       ab  [2];
    logic [3:0] dat [2];
    logic       mo  [2];
    logic       s1  [2];
    logic       s2  [2];
    logic       vld [2];
    logic       bsy [2];
    logic [3:0] wrd [2];

    assign mo[0] = dat[0][{s1[0], s2[0]}];
    assign mo[1] = dat[1][{s1[1], s2[1]}];

    mux_scan_ctrl #(.SETTLE(2)) dut0 (
        .clk(clk), .reset(rst[0]), .start(st[0]), .abort(ab[0]),
        .mux_out(mo[0]), .s1(s1[0]), .s2(s2[0]), .word(wrd[0]),
        .valid(vld[0]), .busy(bsy[0])
    );

    mux_scan_ctrl #(.SETTLE(1)) dut1 (
        .clk(clk), .reset(rst[1]), .start(st[1]), .abort(ab[1]),
        .mux_out(mo[1]), .s1(s1[1]), .s2(s2[1]), .word(wrd[1]),
        .valid(vld[1]), .busy(bsy[1])
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference model: a scan is a timeline t = edges since acceptance;
    // channel k is read at t = (k+1)*S from the data it should see.
    int         S      [2] = '{2, 1};
    bit         m_busy [2];
    bit         m_valid[2];
    int         m_t    [2];
    logic [3:0] m_word [2];
    logic [3:0] m_sh   [2];

    always @(posedge clk) begin
        for (int j = 0; j < 2; j++) begin
            if (rst[j]) begin
                m_busy[j]  = 1'b0;
                m_valid[j] = 1'b0;
                m_t[j]     = 0;
                m_word[j]  = 4'd0;
                m_sh[j]    = 4'd0;
            end else begin
                m_valid[j] = 1'b0;
                if (!m_busy[j]) begin
                    if (st[j]) begin
                        m_busy[j] = 1'b1;
                        m_t[j]    = 0;
                    end
                end else if (ab[j]) begin
                    m_busy[j] = 1'b0;
                end else begin
                    m_t[j]++;
                    if (m_t[j] % S[j] == 0) begin
                        int k;
                        k = m_t[j] / S[j] - 1;
                        m_sh[j][k] = dat[j][k];
                        if (k == 3) begin
                            m_word[j]  = m_sh[j];
                            m_valid[j] = 1'b1;
                            m_busy[j]  = 1'b0;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int j = 0; j < 2; j++) begin
                int es;
                es = m_busy[j] ? m_t[j] / S[j] : 0;
                check($sformatf("model%0d_sel", j), {s1[j], s2[j]}, es);
                check($sformatf("model%0d_busy", j), bsy[j], m_busy[j]);
                check($sformatf("model%0d_valid", j), vld[j], m_valid[j]);
                check($sformatf("model%0d_word", j), wrd[j], m_word[j]);
            end
        end
    end

    typedef struct {
        logic       st;
        logic       ab;
        logic [3:0] dat;
        logic [1:0] sel;
        logic       busy;
        logic       vld;
        logic [3:0] word;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int n, c0, c1, nv, edges;
        logic [3:0] w0, w1;

        tbl[0] = '{1'b1, 1'b0, 4'b1111, 2'd0, 1'b1, 1'b0, 4'b0000};
        tbl[1] = '{1'b0, 1'b0, 4'b1111, 2'd0, 1'b1, 1'b0, 4'b0000};
        tbl[2] = '{1'b0, 1'b0, 4'b1101, 2'd1, 1'b1, 1'b0, 4'b0000};
        tbl[3] = '{1'b0, 1'b0, 4'b1100, 2'd1, 1'b1, 1'b0, 4'b0000};
        tbl[4] = '{1'b0, 1'b0, 4'b1100, 2'd2, 1'b1, 1'b0, 4'b0000};
        tbl[5] = '{1'b0, 1'b0, 4'b1100, 2'd2, 1'b1, 1'b0, 4'b0000};
        tbl[6] = '{1'b0, 1'b0, 4'b1100, 2'd3, 1'b1, 1'b0, 4'b0000};
        tbl[7] = '{1'b0, 1'b0, 4'b1100, 2'd3, 1'b1, 1'b0, 4'b0000};
        tbl[8] = '{1'b0, 1'b0, 4'b1100, 2'd0, 1'b0, 1'b1, 4'b1101};
        tbl[9] = '{1'b0, 1'b0, 4'b1100, 2'd0, 1'b0, 1'b0, 4'b1101};

        // Reset with start held: no scan may begin.
        for (int j = 0; j < 2; j++) begin
            rst[j] = 1'b1;
            st[j]  = 1'b1;
            ab[j]  = 1'b0;
            dat[j] = 4'b1111;
        end
        tick;
        tick;
        tick;
        check("rst_sel", {s1[0], s2[0]}, 2'd0);
        check("rst_word", wrd[0], 4'd0);
        check("rst_valid", vld[0], 1'b0);
        check("rst_busy", bsy[0], 1'b0);
        for (int j = 0; j < 2; j++) begin
            rst[j] = 1'b0;
            st[j]  = 1'b0;
        end
        chk_en = 1'b1;
        tick;
        check("post_rst_busy", bsy[0], 1'b0);

        // Directed SETTLE=2 scan of a,b,c,d = 1,0,1,1 with data moving
        // only while the select is elsewhere.
        for (int i = 0; i < 10; i++) begin
            st[0]  = tbl[i].st;
            ab[0]  = tbl[i].ab;
            dat[0] = tbl[i].dat;
            tick;
            check($sformatf("tbl%0d_sel", i), {s1[0], s2[0]}, tbl[i].sel);
            check($sformatf("tbl%0d_busy", i), bsy[0], tbl[i].busy);
            check($sformatf("tbl%0d_valid", i), vld[0], tbl[i].vld);
            check($sformatf("tbl%0d_word", i), wrd[0], tbl[i].word);
        end

        // Back-to-back scans with start held high.
        dat[0] = 4'b0010;
        st[0]  = 1'b1;
        n = 0; c0 = 0; c1 = 0; w0 = '0; w1 = '0;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (vld[0]) begin
                if (n == 0) begin
                    c0 = i; w0 = wrd[0]; dat[0] = 4'b1111;
                end else begin
                    c1 = i; w1 = wrd[0]; st[0] = 1'b0;
                end
                n++;
            end
            if (n == 2) break;
        end
        st[0] = 1'b0;
        check("b2b_count", n, 2);
        check("b2b_spacing", c1 - c0, 9);
        check("b2b_word0", w0, 4'b0010);
        check("b2b_word1", w1, 4'b1111);
        tick;
        tick;
        check("b2b_idle", bsy[0], 1'b0);

        // Abort at E0+5 while channel c is selected.
        dat[0] = 4'b0000;
        st[0]  = 1'b1;
        tick;
        st[0] = 1'b0;
        repeat (4) tick;
        check("abort_presel", {s1[0], s2[0]}, 2'd2);
        ab[0] = 1'b1;
        tick;
        ab[0] = 1'b0;
        check("abort_busy", bsy[0], 1'b0);
        check("abort_sel", {s1[0], s2[0]}, 2'd0);
        check("abort_valid", vld[0], 1'b0);
        check("abort_word", wrd[0], 4'b1111);
        nv = 0;
        repeat (10) begin
            tick;
            if (vld[0]) nv++;
        end
        check("abort_novalid", nv, 0);
        dat[0] = 4'b1010;
        st[0]  = 1'b1;
        tick;
        st[0] = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (vld[0]) begin
                n = 1;
                break;
            end
        end
        check("rescan_seen", n, 1);
        check("rescan_word", wrd[0], 4'b1010);

        // SETTLE=1: reset at E0+3 mid-scan.
        dat[1] = 4'b1111;
        st[1]  = 1'b1;
        tick;
        st[1] = 1'b0;
        tick;
        tick;
        rst[1] = 1'b1;
        tick;
        rst[1] = 1'b0;
        check("s1rst_sel", {s1[1], s2[1]}, 2'd0);
        check("s1rst_busy", bsy[1], 1'b0);
        check("s1rst_valid", vld[1], 1'b0);
        check("s1rst_word", wrd[1], 4'd0);
        nv = 0;
        repeat (6) begin
            tick;
            if (vld[1]) nv++;
        end
        check("s1rst_novalid", nv, 0);

        // SETTLE=1 scan of a,b,c,d = 0,1,1,0: valid after 5 edges.
        dat[1] = 4'b0110;
        st[1]  = 1'b1;
        tick;
        st[1] = 1'b0;
        edges = 0;
        for (int i = 2; i < 12; i++) begin
            tick;
            if (vld[1]) begin
                edges = i;
                break;
            end
        end
        check("s1_latency", edges, 5);
        check("s1_word", wrd[1], 4'b0110);

        // SETTLE=1 abort on the final sample edge.
        dat[1] = 4'b0000;
        st[1]  = 1'b1;
        tick;
        st[1] = 1'b0;
        repeat (3) tick;
        ab[1] = 1'b1;
        tick;
        ab[1] = 1'b0;
        check("s1abort_valid", vld[1], 1'b0);
        check("s1abort_busy", bsy[1], 1'b0);
        check("s1abort_word", wrd[1], 4'b0110);

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            for (int j = 0; j < 2; j++) begin
                rst[j] = ($urandom_range(63) == 0);
                st[j]  = ($urandom_range(2) == 0);
                ab[j]  = ($urandom_range(9) == 0);
                if ($urandom_range(3) == 0) dat[j] = 4'($urandom);
            end
            tick;
        end
        for (int j = 0; j < 2; j++) begin
            rst[j] = 1'b0;
            st[j]  = 1'b0;
            ab[j]  = 1'b0;
        end
        tick;
        chk_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
